// File: rtl/adder_pkg.sv
// Shared constants for the adder/subtractor family: default operand width
// and the register values the arithmetic leaves take while in reset.
package adder_pkg;

    localparam int ADDER_WIDTH = 4;

    localparam logic [ADDER_WIDTH-1:0] SUM_RST = '0;
    localparam logic                   CO_RST  = 1'b0;
    localparam logic                   V_RST   = 1'b0;

endpackage

// File: rtl/full_adder.sv
// One-bit full-adder cell; the ripple chain in four_bit_adder is built from these.
module full_adder (
    input  logic a,
    input  logic b,
    input  logic cin,
    output logic s,
    output logic cout
);

    logic p;

    assign p    = a ^ b;
    assign s    = p ^ cin;
    assign cout = (a & b) | (cin & p);

endmodule

// File: rtl/four_bit_adder.sv
// Registered ripple-carry adder with carry-in, carry-out and two's-complement
// overflow flag; one cycle of latency, one result per cycle.
module four_bit_adder
    import adder_pkg::*;
#(
    parameter int WIDTH = ADDER_WIDTH
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    input  logic             Cin,
    output logic [WIDTH-1:0] Sum,
    output logic             Co,
    output logic             V
);

    logic [WIDTH:0]   carry_p0;
    logic [WIDTH-1:0] sum_p0;
    logic             ovf_p0;

    assign carry_p0[0] = Cin;

    for (genvar i = 0; i < WIDTH; i++) begin : g_chain
        full_adder u_fa (
            .a    (A[i]),
            .b    (B[i]),
            .cin  (carry_p0[i]),
            .s    (sum_p0[i]),
            .cout (carry_p0[i+1])
        );
    end

    // Signed overflow: carry into the sign bit disagrees with carry out of it.
    assign ovf_p0 = carry_p0[WIDTH] ^ carry_p0[WIDTH-1];

    // Stage p0 -> output register bank.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            Sum <= WIDTH'(SUM_RST);
            Co  <= CO_RST;
            V   <= V_RST;
        end else begin
            Sum <= sum_p0;
            Co  <= carry_p0[WIDTH];
            V   <= ovf_p0;
        end
    end

endmodule

// File: tb/tb_four_bit_adder.sv
// Self-checking bench for four_bit_adder: directed table, sweep, exhaustive,
// random vectors and reset corner cases against an arithmetic reference model.
module tb_four_bit_adder;

    logic       clk = 1'b0;
    logic       rst;
    logic [3:0] A;
    logic [3:0] B;
    logic       Cin;
    logic [3:0] Sum;
    logic       Co;
    logic       V;

    int n_cmp = 0;
    int n_err = 0;

    four_bit_adder dut (
        .clk (clk),
        .rst (rst),
        .A   (A),
        .B   (B),
        .Cin (Cin),
        .Sum (Sum),
        .Co  (Co),
        .V   (V)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [3:0] a;
        logic [3:0] b;
        logic       cin;
        logic [3:0] sum;
        logic       co;
        logic       v;
    } vec_t;

    // Reference: plain integer arithmetic, unsigned for Co/Sum, signed range for V.
    function automatic logic [5:0] model(input int a, input int b, input int cin);
        int u;
        int sa;
        int sb;
        int s;
        logic co;
        logic v;
        logic [3:0] sm;
        u  = a + b + cin;
        sa = (a >= 8) ? a - 16 : a;
        sb = (b >= 8) ? b - 16 : b;
        s  = sa + sb + cin;
        co = (u > 15);
        v  = (s > 7) || (s < -8);
        sm = 4'(u % 16);
        return {co, v, sm};
    endfunction

    task automatic check(input string name, input logic [5:0] exp);
        n_cmp++;
        if ({Co, V, Sum} !== exp) begin
            n_err++;
            $display("FAIL %s: got Co=%b V=%b Sum=%0d, expected Co=%b V=%b Sum=%0d",
                     name, Co, V, Sum, exp[5], exp[4], exp[3:0]);
        end
    endtask

    task automatic apply(input logic [3:0] a, input logic [3:0] b, input logic cin);
        @(negedge clk);
        A   = a;
        B   = b;
        Cin = cin;
        @(posedge clk);
        #1;
    endtask

    vec_t tbl[6];

    initial begin
        tbl[0] = '{a: 4'd15, b: 4'd15, cin: 1'b1, sum: 4'd15, co: 1'b1, v: 1'b0};
        tbl[1] = '{a: 4'd1,  b: 4'd11, cin: 1'b1, sum: 4'd13, co: 1'b0, v: 1'b0};
        tbl[2] = '{a: 4'd4,  b: 4'd14, cin: 1'b0, sum: 4'd2,  co: 1'b1, v: 1'b0};
        tbl[3] = '{a: 4'd7,  b: 4'd1,  cin: 1'b0, sum: 4'd8,  co: 1'b0, v: 1'b1};
        tbl[4] = '{a: 4'd8,  b: 4'd8,  cin: 1'b0, sum: 4'd0,  co: 1'b1, v: 1'b1};
        tbl[5] = '{a: 4'd0,  b: 4'd0,  cin: 1'b0, sum: 4'd0,  co: 1'b0, v: 1'b0};

        // Reset asserted with all-ones operands: outputs zero before any edge.
        rst = 1'b1;
        A   = 4'd15;
        B   = 4'd15;
        Cin = 1'b1;
        #2;
        check("reset_async", 6'b0);
        @(posedge clk);
        #1;
        check("reset_hold", 6'b0);
        @(negedge clk);
        rst = 1'b0;
        @(posedge clk);
        #1;
        check("reset_release", {1'b1, 1'b0, 4'd15});

        // Directed table
        for (int i = 0; i < 6; i++) begin
            apply(tbl[i].a, tbl[i].b, tbl[i].cin);
            check($sformatf("table_%0d", i), {tbl[i].co, tbl[i].v, tbl[i].sum});
        end

        // Inputs changing between edges must not disturb the registered result.
        apply(4'd7, 4'd1, 1'b0);
        A   = 4'd3;
        B   = 4'd9;
        Cin = 1'b1;
        #2;
        check("between_edges", {1'b0, 1'b1, 4'd8});

        // Sweep with a mid-stream reset pulse between edges at i = 6.
        for (int i = 0; i < 16; i++) begin
            logic [3:0] a;
            logic [3:0] b;
            logic       cin;
            a   = 4'(i);
            b   = 4'((i + 10) % 16);
            cin = (i % 4 != 0);
            if (i == 6) begin
                @(negedge clk);
                A   = a;
                B   = b;
                Cin = cin;
                #1;
                rst = 1'b1;
                #1;
                check("midreset_drop", 6'b0);
                #1;
                rst = 1'b0;
                #1;
                check("midreset_low", 6'b0);
                @(posedge clk);
                #1;
            end else begin
                apply(a, b, cin);
            end
            check($sformatf("sweep_%0d", i), model(i, (i + 10) % 16, (i % 4 != 0) ? 1 : 0));
        end

        // Reset held across an edge discards the in-flight operands.
        @(negedge clk);
        A   = 4'd8;
        B   = 4'd9;
        Cin = 1'b1;
        rst = 1'b1;
        @(posedge clk);
        #1;
        check("reset_discard", 6'b0);
        @(negedge clk);
        rst = 1'b0;
        A   = 4'd5;
        B   = 4'd6;
        Cin = 1'b0;
        @(posedge clk);
        #1;
        check("post_reset_first", model(5, 6, 0));

        // Exhaustive 512 combinations
        for (int k = 0; k < 512; k++) begin
            int a;
            int b;
            int c;
            a = k % 16;
            b = (k / 16) % 16;
            c = k / 256;
            apply(4'(a), 4'(b), c[0]);
            check("exhaustive", model(a, b, c));
        end

        // Random vectors
        for (int k = 0; k < 200; k++) begin
            int a;
            int b;
            int c;
            a = int'($urandom_range(15, 0));
            b = int'($urandom_range(15, 0));
            c = int'($urandom_range(1, 0));
            apply(4'(a), 4'(b), c[0]);
            check("random", model(a, b, c));
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
